// File: rtl/scaler_pkg.sv
// Shared types for the scaler input feeder.
// Holds the FSM encoding and the RGB565 colour-bar table.
package scaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WFRM,
    ST_WLINE,
    ST_SEND
  } state_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

endpackage

// File: rtl/scaler_frame_feeder_if.sv
// Scaler-side and upstream-stream signals of the frame feeder.
// master = feeder view, slave = source/scaler environment view.
interface scaler_frame_feeder_if #(
  parameter int DW = 16
);
  logic          v_valid;
  logic          h_valid;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_sof;
  logic          s_ready;
  logic [DW-1:0] dIn;
  logic          dInEn;

  modport master (
    input  v_valid, h_valid,
    input  s_data, s_valid, s_sof,
    output s_ready, dIn, dInEn
  );

  modport slave (
    output v_valid, h_valid,
    output s_data, s_valid, s_sof,
    input  s_ready, dIn, dInEn
  );
endinterface

// File: rtl/scaler_bar_gen.sv
// Colour-bar generator: tracks bar index along a line without a divider.
// Ports: clk, rst_n, step (pixel sent), x, xres (latched) in; colour out.
module scaler_bar_gen
  import scaler_pkg::*;
#(
  parameter int IRW = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step,
  input  logic [IRW-1:0] x,
  input  logic [IRW-1:0] xres,
  output logic [15:0]    colour
);

  logic [IRW-1:0] cnt;
  logic [IRW-1:0] cur_cnt;
  logic [IRW-1:0] w;
  logic [2:0]     bar;
  logic [2:0]     cur_bar;

  assign w = xres >> 3;

  // x==0 marks a fresh line, so the stored bar state is ignored there.
  always_comb begin
    cur_cnt = (x == '0) ? '0 : cnt;
    cur_bar = (x == '0) ? '0 : bar;
    colour  = BAR_RGB[cur_bar];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      bar <= '0;
    end else if (step) begin
      if (cur_cnt == w - IRW'(1)) begin
        cnt <= '0;
        bar <= (cur_bar == 3'd7) ? cur_bar : cur_bar + 3'd1;
      end else begin
        cnt <= cur_cnt + IRW'(1);
        bar <= cur_bar;
      end
    end
  end

endmodule

// File: rtl/scaler_frame_feeder.sv
// Feeds exactly inXRes x inYRes pixels per frame to the scaler.
// Ports: clka, rst_n, en, pattern_en, inXRes, inYRes, bus, busy, underrun, resync.
module scaler_frame_feeder
  import scaler_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int INPUT_RES_WIDTH = 11
) (
  input  logic                       clka,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       pattern_en,
  input  logic [INPUT_RES_WIDTH-1:0] inXRes,
  input  logic [INPUT_RES_WIDTH-1:0] inYRes,
  scaler_frame_feeder_if.master      bus,
  output logic                       busy,
  output logic                       underrun,
  output logic                       resync
);

  localparam int IRW = INPUT_RES_WIDTH;

  state_t         state, state_n;
  logic           v_q, v_d, h_q, h_d;
  logic [IRW-1:0] x, x_n, y, y_n;
  logic [IRW-1:0] xres_l, yres_l;
  logic [IRW-1:0] cur_x, cur_y;
  logic           pat_l, synced;
  logic           v_rise, h_rise, h_fall;
  logic           beat, sof_beat, realign, last;
  logic           frame_start, set_under, set_resync;
  logic [15:0]    colour;

  assign v_rise = v_q & ~v_d;
  assign h_rise = h_q & ~h_d;
  assign h_fall = ~h_q & h_d;

  assign beat     = (state == ST_SEND) & (pat_l | bus.s_valid);
  assign sof_beat = beat & ~pat_l & bus.s_sof;
  assign realign  = sof_beat & ((x != '0) | (y != '0));
  // An s_sof pixel becomes pixel (0,0) of the frame.
  assign cur_x    = realign ? '0 : x;
  assign cur_y    = realign ? '0 : y;
  assign last     = beat & (cur_x == xres_l - IRW'(1));

  // Until the frame start pixel has been taken, non-sof pixels are dropped.
  assign bus.s_ready = ~pat_l & ((state == ST_SEND) |
                       ((state != ST_IDLE) & ~synced & ~bus.s_sof));
  assign bus.dInEn   = beat;
  assign bus.dIn     = !beat ? '0 :
                       pat_l ? DATA_WIDTH'(colour) : bus.s_data;
  assign busy        = (state == ST_WLINE) | (state == ST_SEND);

  scaler_bar_gen #(.IRW(IRW)) u_bar (
    .clk    (clka),
    .rst_n  (rst_n),
    .step   (beat),
    .x      (x),
    .xres   (xres_l),
    .colour (colour)
  );

  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    frame_start = 1'b0;
    set_under   = 1'b0;
    set_resync  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en) state_n = ST_WFRM;
      end
      ST_WFRM: begin
        if (!en) state_n = ST_IDLE;
        else if (v_rise) frame_start = 1'b1;
      end
      ST_WLINE: begin
        if (v_rise) begin
          frame_start = 1'b1;
        end else if (h_rise) begin
          x_n     = '0;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        if (v_rise) begin
          frame_start = 1'b1;
          set_under   = 1'b1;
        end else begin
          set_resync = realign;
          if (beat) begin
            x_n = cur_x + IRW'(1);
            y_n = cur_y;
          end
          // A finishing pixel wins over a simultaneous h_valid fall.
          if (last | h_fall) begin
            set_under = ~last;
            if (cur_y == yres_l - IRW'(1)) begin
              state_n = ST_WFRM;
            end else begin
              y_n     = cur_y + IRW'(1);
              state_n = ST_WLINE;
            end
          end
        end
      end
    endcase
    if (frame_start) begin
      state_n = ST_WLINE;
      x_n     = '0;
      y_n     = '0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      v_q      <= 1'b0;
      v_d      <= 1'b0;
      h_q      <= 1'b0;
      h_d      <= 1'b0;
      x        <= '0;
      y        <= '0;
      xres_l   <= '0;
      yres_l   <= '0;
      pat_l    <= 1'b0;
      synced   <= 1'b0;
      underrun <= 1'b0;
      resync   <= 1'b0;
    end else begin
      state <= state_n;
      v_q   <= bus.v_valid;
      v_d   <= v_q;
      h_q   <= bus.h_valid;
      h_d   <= h_q;
      x     <= x_n;
      y     <= y_n;
      if (frame_start) begin
        xres_l   <= inXRes;
        yres_l   <= inYRes;
        pat_l    <= pattern_en;
        synced   <= 1'b0;
        resync   <= 1'b0;
        underrun <= set_under;
      end else begin
        underrun <= underrun | set_under;
        resync   <= resync | set_resync;
        if (sof_beat) synced <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scaler_frame_feeder.sv
// Self-checking bench for scaler_frame_feeder.
// Reference: colour bars from x/(xres/8), stream output = upstream order.
module tb_scaler_frame_feeder;

  typedef struct packed {
    logic        sof;
    logic [15:0] d;
  } pix_t;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pattern_en = 1'b1;
  logic [10:0] inXRes = 11'd16;
  logic [10:0] inYRes = 11'd2;
  logic        busy, underrun, resync;

  scaler_frame_feeder_if #(.DW(16)) bus ();

  scaler_frame_feeder dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .en         (en),
    .pattern_en (pattern_en),
    .inXRes     (inXRes),
    .inYRes     (inYRes),
    .bus        (bus.master),
    .busy       (busy),
    .underrun   (underrun),
    .resync     (resync)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bar_colour(input int x, input int xres);
    int b;
    logic r, g, bl;
    b = x / (xres / 8);
    if (b > 7) b = 7;
    r  = ((b / 2) % 2) == 0;
    g  = b < 4;
    bl = (b % 2) == 0;
    return {r ? 5'h1F : 5'h00, g ? 6'h3F : 6'h00, bl ? 5'h1F : 5'h00};
  endfunction

  // Reference model and per-cycle comparison.
  logic [15:0] exp_q[$];
  pix_t        up_q[$];
  int          beats = 0;
  int          line_x = 0;
  int          xres_m = 16;
  bit          pat_m = 1'b1;
  logic        vv_p = 1'b0, hv_p = 1'b0;
  logic [15:0] first_pix = '0, last_pix = '0;

  always @(negedge clka) begin
    logic [15:0] e;
    bit have;
    if (bus.v_valid && !vv_p) begin
      xres_m = int'(inXRes);
      pat_m  = pattern_en;
    end
    if (bus.h_valid && !hv_p) line_x = 0;
    vv_p = bus.v_valid;
    hv_p = bus.h_valid;
    if (bus.dInEn === 1'b1) begin
      if (pat_m) begin
        e = bar_colour(line_x, xres_m);
        have = 1'b1;
      end else begin
        have = exp_q.size() > 0;
        e = have ? exp_q.pop_front() : 16'h0;
        chk("stream_beat_expected", 32'(have), 32'd1);
      end
      if (have) chk("dIn", 32'(bus.dIn), 32'(e));
      if (line_x == 0) first_pix = bus.dIn;
      last_pix = bus.dIn;
      line_x++;
      beats++;
    end
  end

  // Upstream stream source: 0 toggle, 1 always valid, 2 random.
  int valid_mode = 0;
  initial begin
    bit hs, phase, v;
    phase = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_sof = 1'b0;
    bus.s_data = '0;
    forever begin
      @(negedge clka);
      hs = (bus.s_valid & bus.s_ready) === 1'b1;
      @(posedge clka);
      #1;
      if (hs && up_q.size() > 0) void'(up_q.pop_front());
      phase = ~phase;
      v = (valid_mode == 0) ? phase :
          (valid_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (up_q.size() == 0) v = 1'b0;
      bus.s_valid = v;
      bus.s_sof   = (up_q.size() > 0) ? up_q[0].sof : 1'b0;
      bus.s_data  = (up_q.size() > 0) ? up_q[0].d : 16'h0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic start_frame();
    bus.v_valid = 1'b1;
    tick(4);
  endtask

  task automatic end_frame();
    bus.v_valid = 1'b0;
    tick(3);
  endtask

  task automatic run_line(input int n);
    int b0, k;
    b0 = beats;
    k = 0;
    bus.h_valid = 1'b1;
    while (beats - b0 < n && k < 20000) begin
      tick();
      k++;
    end
    bus.h_valid = 1'b0;
    tick(4);
    chk("line_beats", 32'(beats - b0), 32'(n));
  endtask

  task automatic push_frame(input int n, input int sof2);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.d   = 16'($urandom);
      p.sof = (i == 0) || (i == sof2);
      up_q.push_back(p);
      exp_q.push_back(p.d);
    end
  endtask

  initial begin
    int b0, b1, k, xr, yr;
    bus.v_valid = 1'b0;
    bus.h_valid = 1'b0;

    // Reset state
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_resync", 32'(resync), 0);
    chk("rst_dInEn", 32'(bus.dInEn), 0);
    chk("rst_dIn", 32'(bus.dIn), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    rst_n = 1'b1;
    en = 1'b1;
    tick(2);

    // Colour bars, 16x2: two beats per bar
    pattern_en = 1'b1;
    inXRes = 11'd16;
    inYRes = 11'd2;
    start_frame();
    b0 = beats;
    run_line(16);
    run_line(16);
    chk("pat_total", 32'(beats - b0), 32'd32);
    chk("pat_first", 32'(first_pix), 32'h0000FFFF);
    chk("pat_last", 32'(last_pix), 32'h00000000);
    chk("pat_frame_end_busy", 32'(busy), 0);
    end_frame();

    // Random pattern geometries
    repeat (3) begin
      xr = $urandom_range(8, 40);
      yr = $urandom_range(1, 3);
      inXRes = 11'(xr);
      inYRes = 11'(yr);
      start_frame();
      for (int l = 0; l < yr; l++) run_line(xr);
      chk("rnd_pat_busy", 32'(busy), 0);
      end_frame();
    end

    // Stream, s_valid toggling, 1024 per line
    pattern_en = 1'b0;
    valid_mode = 0;
    inXRes = 11'd1024;
    inYRes = 11'd2;
    push_frame(2048, -1);
    start_frame();
    run_line(1024);
    run_line(1024);
    chk("stream_busy", 32'(busy), 0);
    chk("stream_consumed", 32'(exp_q.size()), 0);
    end_frame();

    // Stream with random s_valid
    valid_mode = 2;
    xr = $urandom_range(8, 64);
    inXRes = 11'(xr);
    inYRes = 11'd3;
    push_frame(xr * 3, -1);
    start_frame();
    for (int l = 0; l < 3; l++) run_line(xr);
    chk("rnd_stream_busy", 32'(busy), 0);
    chk("rnd_stream_consumed", 32'(exp_q.size()), 0);
    end_frame();

    // s_sof at x=5,y=3 restarts the frame from that pixel
    valid_mode = 1;
    inXRes = 11'd16;
    inYRes = 11'd4;
    push_frame(117, 53);
    start_frame();
    run_line(16);
    run_line(16);
    run_line(16);
    chk("pre_resync", 32'(resync), 0);
    run_line(21);
    chk("resync_set", 32'(resync), 1);
    run_line(16);
    run_line(16);
    chk("resync_busy_mid", 32'(busy), 1);
    run_line(16);
    chk("resync_busy_end", 32'(busy), 0);
    chk("resync_consumed", 32'(exp_q.size()), 0);
    end_frame();

    // h_valid drops after 100 pixels; the fall is seen two
    // cycles later, so two more pattern pixels leave.
    pattern_en = 1'b1;
    inXRes = 11'd1024;
    inYRes = 11'd2;
    start_frame();
    chk("resync_cleared", 32'(resync), 0);
    b0 = beats;
    k = 0;
    bus.h_valid = 1'b1;
    while (beats - b0 < 100 && k < 2000) begin
      tick();
      k++;
    end
    bus.h_valid = 1'b0;
    tick(10);
    chk("underrun_set", 32'(underrun), 1);
    chk("underrun_beats", 32'(beats - b0), 32'd102);
    chk("underrun_busy", 32'(busy), 1);
    b1 = beats;
    tick(20);
    chk("underrun_idle_beats", 32'(beats - b1), 0);
    run_line(1024);
    chk("underrun_y_advanced", 32'(busy), 0);
    end_frame();

    // Resolution change mid-frame applies to the next frame only
    start_frame();
    chk("underrun_cleared", 32'(underrun), 0);
    inXRes = 11'd512;
    run_line(1024);
    run_line(1024);
    chk("xchg_busy1", 32'(busy), 0);
    end_frame();
    start_frame();
    run_line(512);
    run_line(512);
    chk("xchg_busy2", 32'(busy), 0);
    end_frame();

    // Asynchronous reset in the middle of a line
    inXRes = 11'd64;
    inYRes = 11'd1;
    start_frame();
    b0 = beats;
    k = 0;
    bus.h_valid = 1'b1;
    while (beats - b0 < 10 && k < 200) begin
      tick();
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dInEn", 32'(bus.dInEn), 0);
    chk("arst_dIn", 32'(bus.dIn), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_s_ready", 32'(bus.s_ready), 0);
    bus.h_valid = 1'b0;
    bus.v_valid = 1'b0;
    en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    bus.v_valid = 1'b1;
    tick(6);
    chk("idle_ignores_frame", 32'(busy), 0);
    end_frame();

    // Recovery after reset
    en = 1'b1;
    tick(2);
    inXRes = 11'd8;
    start_frame();
    chk("recover_busy", 32'(busy), 1);
    run_line(8);
    chk("recover_done", 32'(busy), 0);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
